// File: rtl/sparse_hv_pkg.sv
// Shared types and constants for the sparse hypervector generator.
// The LFSR step lives here so every user agrees on the polynomial.
package sparse_hv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GENERATE = 2'd1,
    HOLD     = 2'd2
  } fsm_state;

  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] LFSR_RESET = 16'h0001;

  // Galois right-shift step; never maps a non-zero state to zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/sparse_hv_generator_lfsr.sv
// 16-bit Galois LFSR with seed load; a zero seed is replaced so the
// register can never lock up in the all-zero state.
import sparse_hv_pkg::*;

module lfsr_galois_16 (
  input  logic        clk,
  input  logic        arst_n_in,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        enable,
  output logic [15:0] state_out
);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_out <= LFSR_RESET;
    end else if (load) begin
      state_out <= (load_value == 16'h0000) ? LFSR_RESET : load_value;
    end else if (enable) begin
      state_out <= lfsr_step(state_out);
    end
  end

endmodule

// File: rtl/sparse_hv_generator.sv
// Serial generator of sparse segmented hypervectors: one set bit per
// segment, one segment per cycle, handed off over valid/ready.
import sparse_hv_pkg::*;

module sparse_hv_generator #(
  parameter int LENGTH_VECTOR  = 32,
  parameter int SEGMENT_LENGTH = 8
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic [15:0]              seed_in,
  input  logic                     seed_load,
  input  logic                     start,
  output logic                     busy,
  output logic [LENGTH_VECTOR-1:0] hv_out,
  output logic                     hv_valid,
  input  logic                     hv_ready
);

  localparam int NUM_SEGMENTS   = LENGTH_VECTOR / SEGMENT_LENGTH;
  localparam int LENGTH_POS     = $clog2(SEGMENT_LENGTH);
  localparam int LENGTH_SEG_CNT = $clog2(NUM_SEGMENTS) + 1;
  localparam int IDX_W          = $clog2(LENGTH_VECTOR);

  fsm_state                  state;
  fsm_state                  state_next;
  logic [LENGTH_SEG_CNT-1:0] seg_cnt;
  logic [15:0]               lfsr_state;
  logic                      lfsr_load;
  logic                      lfsr_enable;
  logic                      last_seg;
  logic [IDX_W-1:0]          bit_idx;
  logic [LENGTH_VECTOR-1:0]  bit_mask;
  logic                      unused_lfsr_hi;

  lfsr_galois_16 u_lfsr (
    .clk        (clk),
    .arst_n_in  (arst_n_in),
    .load       (lfsr_load),
    .load_value (seed_in),
    .enable     (lfsr_enable),
    .state_out  (lfsr_state)
  );

  // Only the low LENGTH_POS bits pick a position; the rest just feed the sequence.
  assign unused_lfsr_hi = ^lfsr_state[15:LENGTH_POS];

  assign last_seg = (seg_cnt == LENGTH_SEG_CNT'(NUM_SEGMENTS - 1));
  assign bit_idx  = IDX_W'(seg_cnt) * IDX_W'(SEGMENT_LENGTH)
                  + IDX_W'(lfsr_state[LENGTH_POS-1:0]);
  assign bit_mask = {{(LENGTH_VECTOR-1){1'b0}}, 1'b1} << bit_idx;

  always_comb begin
    state_next  = state;
    lfsr_load   = 1'b0;
    lfsr_enable = 1'b0;
    case (state)
      IDLE: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
        end else if (start) begin
          state_next = GENERATE;
        end
      end
      GENERATE: begin
        lfsr_enable = 1'b1;
        if (last_seg) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (hv_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // hv_out persists through IDLE so the last vector stays readable until the next start.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      seg_cnt <= '0;
      hv_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !seed_load) begin
            seg_cnt <= '0;
            hv_out  <= '0;
          end
        end
        GENERATE: begin
          hv_out  <= hv_out | bit_mask;
          seg_cnt <= seg_cnt + LENGTH_SEG_CNT'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign hv_valid = (state == HOLD);

endmodule

// File: tb/tb_sparse_hv_generator.sv
// Bench for sparse_hv_generator: vector table, hand-written corner
// sequences and random seeds, checked through an expected-vector queue.
module tb_sparse_hv_generator;

  localparam int LV = 32;
  localparam int SL = 8;
  localparam int NS = LV / SL;

  logic          clk = 1'b0;
  logic          arst_n_in;
  logic [15:0]   seed_in;
  logic          seed_load;
  logic          start;
  logic          busy;
  logic [LV-1:0] hv_out;
  logic          hv_valid;
  logic          hv_ready;
  logic [15:0]   lfsr_now;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [LV-1:0] exp_q[$];
  logic [LV-1:0] mon_exp;

  typedef struct {
    logic          do_seed;
    logic [15:0]   seed;
    logic [LV-1:0] exp_hv;
    logic [15:0]   exp_lfsr;
  } vec_t;

  vec_t tbl[4];

  always #5 clk = ~clk;

  sparse_hv_generator #(.LENGTH_VECTOR(LV), .SEGMENT_LENGTH(SL)) dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .seed_in   (seed_in),
    .seed_load (seed_load),
    .start     (start),
    .busy      (busy),
    .hv_out    (hv_out),
    .hv_valid  (hv_valid),
    .hv_ready  (hv_ready)
  );

  assign lfsr_now = dut.u_lfsr.state_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic int one_hot_segments(input logic [LV-1:0] hv);
    int n = 0;
    for (int k = 0; k < NS; k++) begin
      if ($countones(hv[k*SL +: SL]) == 1) n++;
    end
    return n;
  endfunction

  function automatic int similarity(input logic [LV-1:0] a, input logic [LV-1:0] b);
    return $countones(a & b);
  endfunction

  // Reference: apply the documented Galois step once per segment.
  function automatic logic [LV-1:0] model_hv(input logic [15:0] seed, output logic [15:0] lfsr_end);
    logic [LV-1:0] hv = '0;
    logic [15:0]   s  = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int k = 0; k < NS; k++) begin
      hv[k*SL + int'(s[2:0])] = 1'b1;
      s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    end
    lfsr_end = s;
    return hv;
  endfunction

  // Scoreboard: compare each handed-off vector with the oldest expectation.
  always @(negedge clk) begin
    if (arst_n_in && hv_valid && hv_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_vector: got 0x%08h with no vector outstanding", hv_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("hv_out", hv_out, mon_exp);
        check("popcount", $countones(hv_out), NS);
        check("one_hot_segments", one_hot_segments(hv_out), NS);
        check("self_similarity", similarity(hv_out, hv_out), NS);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!hv_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic run_vector(input logic do_seed, input logic [15:0] seed,
                            input logic [LV-1:0] exp_hv, input logic [15:0] exp_lfsr);
    int cycles;
    if (do_seed) begin
      seed_in   = seed;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
    end
    hv_ready = 1'b1;
    start    = 1'b1;
    exp_q.push_back(exp_hv);
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    wait_valid(cycles);
    check("latency", cycles, NS);
    tick();
    check("valid_one_cycle", hv_valid, 0);
    check("busy_back_idle", busy, 0);
    check("hv_kept_in_idle", hv_out, exp_hv);
    check("lfsr_after", lfsr_now, exp_lfsr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int            cycles;
    logic [15:0]   rseed;
    logic [15:0]   rlfsr;
    logic [LV-1:0] rhv;

    tbl[0] = '{1'b1, 16'h0001, 32'h01010102, 16'h1680};
    tbl[1] = '{1'b0, 16'h0000, 32'h01010101, 16'h0168};
    tbl[2] = '{1'b1, 16'h0000, 32'h01010102, 16'h1680};
    tbl[3] = '{1'b1, 16'h0007, 32'h01020880, 16'h6180};

    arst_n_in = 1'b0;
    seed_in   = 16'h0000;
    seed_load = 1'b0;
    start     = 1'b0;
    hv_ready  = 1'b1;
    #12;
    check("reset_hv_out", hv_out, 0);
    check("reset_hv_valid", hv_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_lfsr", lfsr_now, 16'h0001);
    arst_n_in = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_vector(tbl[i].do_seed, tbl[i].seed, tbl[i].exp_hv, tbl[i].exp_lfsr);
    end

    // seed_load and start together: the load wins, no vector starts
    seed_in   = 16'h0007;
    seed_load = 1'b1;
    start     = 1'b1;
    tick();
    seed_load = 1'b0;
    start     = 1'b0;
    check("priority_busy", busy, 0);
    check("priority_lfsr", lfsr_now, 16'h0007);
    run_vector(1'b0, 16'h0000, 32'h01020880, 16'h6180);

    // back-pressure in HOLD with start/seed_load pulses
    seed_in   = 16'h0001;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    hv_ready  = 1'b0;
    start     = 1'b1;
    exp_q.push_back(32'h01010102);
    tick();
    start = 1'b0;
    wait_valid(cycles);
    check("hold_latency", cycles, NS);
    for (int i = 0; i < 10; i++) begin
      start     = i[0];
      seed_load = ~i[0];
      seed_in   = 16'h1234;
      tick();
      check("hold_valid", hv_valid, 1);
      check("hold_hv_out", hv_out, 32'h01010102);
      check("hold_lfsr", lfsr_now, 16'h1680);
    end
    start     = 1'b0;
    seed_load = 1'b0;
    hv_ready  = 1'b1;
    tick();
    check("hold_release_valid", hv_valid, 0);
    check("hold_release_busy", busy, 0);

    // asynchronous reset during the second GENERATE cycle
    seed_in   = 16'h0001;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    arst_n_in = 1'b0;
    #1;
    check("midreset_hv_out", hv_out, 0);
    check("midreset_hv_valid", hv_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_lfsr", lfsr_now, 16'h0001);
    #1;
    arst_n_in = 1'b1;
    run_vector(1'b0, 16'h0000, 32'h01010102, 16'h1680);

    for (int i = 0; i < 1000; i++) begin
      rseed = 16'($urandom);
      rhv   = model_hv(rseed, rlfsr);
      run_vector(1'b1, rseed, rhv, rlfsr);
    end

    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
